// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: the instruction-memory request/response channel,
// the decode-facing head-of-queue outputs, and the redirect/stall controls
// that steer the fetch unit.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    // Fetch unit side
    modport master (
        input  redirect, redirect_pc, stall,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output id_valid, id_pc, id_inst
    );

    // Memory / pipeline side
    modport slave (
        output redirect, redirect_pc, stall,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a small prefetch queue.
// Owns the fetch PC, keeps at most one memory request outstanding, buffers
// returned words with their PCs and presents the queue head to decode.
// A redirect flushes the queue; a response to a request issued before the
// redirect is marked stale and dropped when it arrives.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          pending;
    logic          stale;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic          resp;
    logic          req;
    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   inflight;

    // A response only counts when we are actually waiting for one.
    assign resp       = bus.imem_rvalid && pending;
    // Occupied entries plus the slot reserved by an outstanding request;
    // a same-cycle pop is deliberately not credited.
    assign inflight   = {1'b0, count} + {{CW{1'b0}}, pending};
    assign req        = !bus.redirect && (!pending || resp)
                        && (inflight < (CW+1)'(DEPTH));
    assign accept     = req && bus.imem_ready;
    assign push       = resp && !stale && !bus.redirect;
    assign head_valid = (count != '0);
    assign pop        = head_valid && !bus.stall && !bus.redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.id_valid  = head_valid;
    assign bus.id_pc     = head_valid ? q_pc[rd_ptr]   : 32'h0;
    assign bus.id_inst   = head_valid ? q_inst[rd_ptr] : 32'h0;

    // Fetch PC, outstanding-request tracking and stale marking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            pending    <= 1'b0;
            stale      <= 1'b0;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc & ~32'h3;
                // An in-flight request now targets the wrong path.
                stale    <= pending && !resp;
                pending  <= pending && !resp;
            end else begin
                if (resp && stale) begin
                    stale <= 1'b0;
                end
                if (accept) begin
                    pending_pc <= fetch_pc;
                    fetch_pc   <= fetch_pc + 32'd4;
                    pending    <= 1'b1;
                end else if (resp) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue storage: written on push only; contents are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= pending_pc;
            q_inst[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven directed vectors, hand-written
// sequences for stale flush, slow memory and asynchronous reset, and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory model: one outstanding request, returned after lat cycles.
    bit          mo_valid = 1'b0;
    int          mo_wait  = 0;
    logic [31:0] mo_addr  = 32'h0;
    int          lat      = 1;
    bit          spur_en  = 1'b0;

    // Values sampled mid-cycle and the response actually driven.
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    typedef struct {
        bit          rs;
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, advance memory model.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        if (mo_valid && mo_wait == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mo_addr ^ KEY;
        end else if (!mo_valid && spur_en && $urandom_range(0, 9) == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        d_rvalid = bus.imem_rvalid;
        d_rdata  = bus.imem_rdata;
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.id_valid;
        s_pc    = bus.id_pc;
        s_inst  = bus.id_inst;
        if (d_rvalid && mo_valid) mo_valid = 1'b0;
        else if (mo_valid) mo_wait--;
        if (s_req && rdy) begin
            mo_valid = 1'b1;
            mo_addr  = s_addr;
            mo_wait  = lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check cleared outputs, release just after an edge.
    task automatic do_reset(input bit keep_mem);
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        bus.stall       = 1'b0;
        rst = 1'b1;
        if (!keep_mem) mo_valid = 1'b0;
        #1;
        chk("rst.id_valid", bus.id_valid, 0);
        chk("rst.id_pc", bus.id_pc, 0);
        chk("rst.id_inst", bus.id_inst, 0);
        chk("rst.imem_addr", bus.imem_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ent_t        rq[$];
        logic [31:0] m_fetch, m_ppc;
        bit          m_pend, m_stale;
        bit          found;

        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // rs st rd rpc rdy | req addr valid pc
        // Stream
        tbl.push_back('{1, 0, 0, 32'h0,   1, 1, 32'h00,  0, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h04,  0, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h08,  1, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h0C,  1, 32'h4});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h8});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h14,  1, 32'hC});
        // Backpressure: stall from reset, fill, then release
        tbl.push_back('{1, 1, 0, 32'h0,   1, 1, 32'h00,  0, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h04,  0, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h08,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h0C,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h4});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h14,  1, 32'h8});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h18,  1, 32'hC});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h1C,  1, 32'h10});
        // Redirect with stall and a full queue, unaligned target
        tbl.push_back('{1, 1, 0, 32'h0,   1, 1, 32'h00,  0, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h04,  0, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h08,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 1, 32'h0C,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 1, 0, 32'h0,   1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 1, 1, 32'h203, 1, 0, 32'h10,  1, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 1, 32'h208, 1, 32'h200});

        lat = 1;
        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset(1'b0);
            step(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("tbl%0d.req", i), s_req, tbl[i].e_req);
            chk($sformatf("tbl%0d.addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.valid", i), s_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d.pc", i), s_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.inst", i), s_inst, tbl[i].e_valid ? (tbl[i].e_pc ^ KEY) : 32'h0);
        end

        // Stale flush: redirect while the request for 0x8 is outstanding
        do_reset(1'b0);
        lat = 1;
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        lat = 2;
        step(0, 0, 32'h0, 1);
        lat = 1;
        step(0, 1, 32'h100, 1);
        chk("stale.req_on_redirect", s_req, 0);
        step(0, 0, 32'h0, 1);
        chk("stale.req_after", s_req, 1);
        chk("stale.addr_after", s_addr, 32'h100);
        chk("stale.valid_after", s_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h0, 1);
            if (s_valid && !found) begin
                found = 1'b1;
                chk("stale.first_pc", s_pc, 32'h100);
            end
        end
        chk("stale.delivered", found, 1);

        // Slow memory: ready low with request held
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0);
            chk("slow.req", s_req, 1);
            chk("slow.addr", s_addr, 32'h0);
            chk("slow.valid", s_valid, 0);
        end
        step(0, 0, 32'h0, 1);
        chk("slow.accept_addr", s_addr, 32'h0);
        step(0, 0, 32'h0, 1);
        chk("slow.next_addr", s_addr, 32'h4);
        chk("slow.valid_resp", s_valid, 0);
        step(0, 0, 32'h0, 1);
        chk("slow.valid_head", s_valid, 1);
        chk("slow.pc_head", s_pc, 32'h0);

        // Asynchronous reset mid-stream, late response afterwards
        do_reset(1'b0);
        lat = 1;
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("areset.pre_valid", s_valid, 1);
        do_reset(1'b1);
        step(0, 0, 32'h0, 1);
        chk("areset.late_rvalid", d_rvalid, 1);
        chk("areset.req", s_req, 1);
        chk("areset.addr", s_addr, 32'h0);
        chk("areset.valid0", s_valid, 0);
        step(0, 0, 32'h0, 1);
        chk("areset.valid1", s_valid, 0);
        step(0, 0, 32'h0, 1);
        chk("areset.valid2", s_valid, 1);
        chk("areset.pc", s_pc, 32'h0);
        chk("areset.inst", s_inst, KEY);

        // Randomized run against the reference model
        do_reset(1'b0);
        rq.delete();
        m_fetch = 32'h0;
        m_ppc   = 32'h0;
        m_pend  = 1'b0;
        m_stale = 1'b0;
        spur_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit          st, rd, rdy, resp, e_req, e_valid;
            logic [31:0] rpc, e_pc, e_inst;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 3);
            step(st, rd, rpc, rdy);

            resp    = d_rvalid && m_pend;
            e_req   = !rd && (!m_pend || resp) && (rq.size() + int'(m_pend) < DEPTH);
            e_valid = (rq.size() > 0);
            e_pc    = e_valid ? rq[0].pc   : 32'h0;
            e_inst  = e_valid ? rq[0].inst : 32'h0;
            chk("rnd.req", s_req, e_req);
            chk("rnd.addr", s_addr, m_fetch);
            chk("rnd.valid", s_valid, e_valid);
            chk("rnd.pc", s_pc, e_pc);
            chk("rnd.inst", s_inst, e_inst);

            if (rd) begin
                rq.delete();
                m_fetch = {rpc[31:2], 2'b00};
                m_stale = m_pend && !resp;
                m_pend  = m_pend && !resp;
            end else begin
                if (e_valid && !st) void'(rq.pop_front());
                if (resp) begin
                    if (m_stale) m_stale = 1'b0;
                    else rq.push_back('{m_ppc, d_rdata});
                end
                if (e_req && rdy) begin
                    m_ppc   = m_fetch;
                    m_fetch = m_fetch + 32'd4;
                    m_pend  = 1'b1;
                end else if (resp) begin
                    m_pend = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with a small prefetch queue. It sits directly upstream of the IF/ID pipeline register in the 5-stage CPU. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request plus response-valid handshake. It buffers returned instructions with their PCs and presents one instruction per cycle to decode. Redirects from branch/jump resolution flush the queue. Load-use stalls freeze the head entry.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  taken branch/jump from MEM; redirect_pc valid this cycle
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- stall  in  1  decode cannot accept this cycle (load-use nop)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (= fetch_pc)
- imem_ready  in  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  in  1  response valid; responses in order, ≥1 cycle after acceptance
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- id_valid  out  1  queue head valid
- id_pc  out  32  PC of head entry; 0 when !id_valid
- id_inst  out  32  instruction of head entry; 0 (bubble) when !id_valid

## Operation
- State:
  - fetch_pc (32)
  - pending (1 bit, at most one outstanding request)
  - pending_pc (32)
  - stale (1 bit)
  - queue: DEPTH x {pc, inst}, with rd/wr pointers and count (0..DEPTH)
- Response effective: resp = imem_rvalid && pending. imem_rvalid with !pending is ignored.
- Request (combinational): imem_req = !redirect && (!pending || resp) && (count + pending < DEPTH). Credit is conservative; a same-cycle pop is not credited.
- Accept (imem_req && imem_ready):
  - pending_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 4 (mod 2^32)
  - pending <= 1
- Response without a new accept: pending <= 0.
- Push: resp && !stale && !redirect writes {pending_pc, imem_rdata} at wr pointer.
- Stale discard: resp && stale drops the data and clears stale.
- Pop: id_valid && !stall && !redirect advances rd pointer.
- Push and pop in the same cycle leave count unchanged.
- Redirect (priority over push, pop, stall, issue):
  - count, rd and wr pointers <= 0
  - fetch_pc <= {redirect_pc[31:2], 2'b00}
  - if pending && !resp: stale <= 1, pending stays 1
  - if resp this cycle: data dropped, pending <= 0
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH, guaranteed by the credit rule.
- imem_addr and imem_req stay stable while imem_req && !imem_ready, unless redirect.

## Timing
- Reset (asynchronous assert, immediate):
  - fetch_pc = RESET_PC
  - count, pending, stale = 0
  - id_valid = 0, id_pc = 0, id_inst = 0
  - imem_addr = RESET_PC; imem_req = 1 from the first cycle after rst deasserts
- Latency: accept in cycle N, rvalid in N+1, push at the end of N+1, id_valid in N+2.
- Throughput: 1 instr/cycle when imem_ready = 1 and rvalid follows acceptance by exactly 1 cycle. The next request issues in the same cycle the response returns.
- Redirect in cycle N:
  - imem_req = 0 in N
  - id_valid = 0 in N+1
  - request to the new target in N+1, or after the stale response returns
- rst asserted mid-operation: all state cleared immediately. Any response to a pre-reset request that arrives after reset is ignored (pending = 0).
- Stall with a full queue: no issue, no pop; head outputs held unchanged.

## Test plan
- Stream: RESET_PC = 0, ready = 1, rvalid one cycle after accept, rdata = addr ^ 32'hA5A5_0000 -> id_pc 0,4,8,12,… on consecutive cycles starting 2 cycles after reset release.
- Backpressure: stall = 1 from reset -> exactly 4 requests (0x0–0xC), count = 4, imem_req low thereafter. Release stall -> id_pc 0,4,8,12 on consecutive cycles, then 0x10 follows.
- Stale flush: redirect_pc = 0x100 asserted while the request for 0x8 is pending; rvalid arrives next cycle -> data dropped, next id_valid shows id_pc 0x100, never 0x8.
- Redirect + stall + full queue, redirect_pc = 0x203 -> id_valid = 0 next cycle, imem_addr = 0x200, first delivered id_pc 0x200.
- Slow memory: imem_ready low 3 cycles with imem_req high -> imem_addr constant, fetch_pc not advanced, no push.
- Async reset mid-stream with a request pending -> outputs zero within the same cycle. A late imem_rvalid after reset is ignored; fetch restarts at RESET_PC.
